spi_pwm_regbank: RTL and testbench

SPI-slave register bank driving N_CH independent PWM channels. SCLK, MOSI and CS_N are oversampled and synchronised into the clk domain, so there is a single clock domain and no CDC hazard on register writes. Registers hold global enable, prescaler, period and per-channel duty. Sits at the top level between the dedicated input pins (SPI) and the output pins (MISO, PWM).

---
 rtl/spi_pwm_pkg.sv | 20 ++
 rtl/spi_slave_if.sv | 90 +++++++++
 rtl/spi_pwm_regbank.sv | 97 +++++++++
 tb/tb_spi_pwm_regbank.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pwm_pkg.sv
// spi_pwm_pkg: register map, control bit positions, reset values and SPI FSM states
package spi_pwm_pkg;

    localparam logic [6:0] ADDR_ID       = 7'h00;
    localparam logic [6:0] ADDR_CTRL     = 7'h01;
    localparam logic [6:0] ADDR_PRESCALE = 7'h02;
    localparam logic [6:0] ADDR_PERIOD   = 7'h03;
    localparam logic [6:0] ADDR_DUTY0    = 7'h04;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_POL = 1;

    localparam logic [1:0] RST_CTRL     = 2'b00;
    localparam logic [7:0] RST_PRESCALE = 8'h00;
    localparam logic [7:0] RST_PERIOD   = 8'hFF;
    localparam logic [7:0] RST_DUTY     = 8'h00;

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: oversampled SPI mode-0 slave turning 16-bit frames into register strobes
module spi_slave_if
    import spi_pwm_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic [7:0] rdata,
    output logic       miso,
    output logic [6:0] addr,
    output logic [7:0] wdata,
    output logic       wr_stb,
    output logic       rd_req
);

    logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, mosi_s, cs_s, rise, fall, cs_fall;
    spi_state_t             state, state_nx;
    logic [3:0]             bcnt;
    logic [6:0]             rx;
    logic [7:0]             tx;
    logic                   rw;

    assign sclk_s  = sclk_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_q[SYNC_STAGES-1];
    assign cs_s    = cs_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign cs_fall = ~cs_s & cs_d;
    assign miso    = (state == DATA) & tx[7];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sclk_q <= '0;
            mosi_q <= '0;
            cs_q   <= '1;
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end

    always_comb begin
        state_nx = cs_s                                         ? IDLE :
                   (state == IDLE && cs_fall)                   ? CMD  :
                   (state == CMD  && rise && bcnt == 4'd7)      ? DATA :
                   (state == DATA && rise && bcnt == 4'd15)     ? DONE : state;
        wr_stb   = state == DATA && rise && bcnt == 4'd15 && rw && !cs_s;
        wdata    = {rx, mosi_s};
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            bcnt   <= '0;
            rx     <= '0;
            tx     <= '0;
            rw     <= 1'b0;
            addr   <= '0;
            rd_req <= 1'b0;
        end else begin
            state  <= state_nx;
            rd_req <= state == CMD && state_nx == DATA;
            if (state == IDLE)
                bcnt <= '0;
            else if (rise) begin
                bcnt <= bcnt + 4'd1;
                rx   <= {rx[5:0], mosi_s};
            end
            if (state == CMD && state_nx == DATA) begin
                rw   <= rx[6];
                addr <= {rx[5:0], mosi_s};
            end
            // the fall right after the 8th rise must keep bit7 on miso for the master
            if (rd_req)
                tx <= rdata;
            else if (state == DATA && fall && bcnt != 4'd8)
                tx <= {tx[6:0], 1'b0};
        end

endmodule

// File: rtl/spi_pwm_regbank.sv
// spi_pwm_regbank: SPI-programmed register bank driving N_CH shadowed PWM channels
module spi_pwm_regbank
    import spi_pwm_pkg::*;
#(
    parameter int         N_CH        = 4,
    parameter logic [7:0] ID_VALUE    = 8'h96,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sclk,
    input  logic            mosi,
    input  logic            cs_n,
    output logic            miso,
    output logic [N_CH-1:0] pwm_out
);

    logic [6:0]      addr;
    logic [7:0]      wdata, rdata, duty_rd;
    logic            wr_stb, rd_req;
    logic [1:0]      ctrl;
    logic [7:0]      prescale, period, period_sh, pcnt, cnt;
    logic [7:0]      duty    [N_CH];
    logic [7:0]      duty_sh [N_CH];
    logic            en, pol, tick, wrap, load_sh;
    logic [N_CH-1:0] raw;

    spi_slave_if #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
        .clk    (clk),
        .rst_n  (rst_n),
        .sclk   (sclk),
        .mosi   (mosi),
        .cs_n   (cs_n),
        .rdata  (rdata),
        .miso   (miso),
        .addr   (addr),
        .wdata  (wdata),
        .wr_stb (wr_stb),
        .rd_req (rd_req)
    );

    assign en   = ctrl[CTRL_EN];
    assign pol  = ctrl[CTRL_POL];
    // >= rather than == so a limit written below the running count still wraps
    assign tick = en && pcnt >= prescale;
    assign wrap = tick && cnt >= period_sh;
    // shadows track while disabled so enabling starts from the current registers
    assign load_sh = !en || wrap;

    always_comb begin
        duty_rd = '0;
        for (int i = 0; i < N_CH; i++)
            if (addr == 7'(ADDR_DUTY0 + i)) duty_rd = duty[i];
    end

    assign rdata = !rd_req                 ? 8'h00         :
                   addr == ADDR_ID         ? ID_VALUE      :
                   addr == ADDR_CTRL       ? {6'b0, ctrl}  :
                   addr == ADDR_PRESCALE   ? prescale      :
                   addr == ADDR_PERIOD     ? period        : duty_rd;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ctrl     <= RST_CTRL;
            prescale <= RST_PRESCALE;
            period   <= RST_PERIOD;
            for (int i = 0; i < N_CH; i++) duty[i] <= RST_DUTY;
        end else if (wr_stb) begin
            if (addr == ADDR_CTRL)     ctrl     <= wdata[1:0];
            if (addr == ADDR_PRESCALE) prescale <= wdata;
            if (addr == ADDR_PERIOD)   period   <= wdata;
            for (int i = 0; i < N_CH; i++)
                if (addr == 7'(ADDR_DUTY0 + i)) duty[i] <= wdata;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pcnt      <= '0;
            cnt       <= '0;
            period_sh <= RST_PERIOD;
            for (int i = 0; i < N_CH; i++) duty_sh[i] <= RST_DUTY;
            pwm_out   <= '0;
        end else begin
            pcnt <= (!en || tick) ? 8'h00 : pcnt + 8'd1;
            cnt  <= (!en || wrap) ? 8'h00 : tick ? cnt + 8'd1 : cnt;
            if (load_sh) begin
                period_sh <= period;
                for (int i = 0; i < N_CH; i++) duty_sh[i] <= duty[i];
            end
            pwm_out <= en ? raw ^ {N_CH{pol}} : {N_CH{pol}};
        end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign raw[g] = cnt < duty_sh[g];
    end

endmodule

// File: tb/tb_spi_pwm_regbank.sv
// tb_spi_pwm_regbank: scoreboard bench with a register-map model and PWM pulse measurement
module tb_spi_pwm_regbank;

    localparam int HALF = 8;

    typedef struct {
        int         kind;
        int         ch;
        int         a;
        int         b;
        int         c;
        logic [3:0] mask;
        logic [3:0] v;
    } req_t;

    logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
    logic       miso;
    logic [3:0] pwm_out;
    int         n_cmp = 0, n_bad = 0, p_req = 0, p_done = 0;
    logic [7:0] rd_q[$];
    req_t       pq[$];
    logic [1:0] m_ctrl;
    logic [7:0] m_pre, m_per;
    logic [7:0] m_duty [4];

    always #5 clk = ~clk;

    spi_pwm_regbank #(.N_CH(4), .ID_VALUE(8'h96), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .mosi    (mosi),
        .cs_n    (cs_n),
        .miso    (miso),
        .pwm_out (pwm_out)
    );

    function automatic void check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void m_reset();
        m_ctrl = 2'b00;
        m_pre  = 8'h00;
        m_per  = 8'hFF;
        for (int i = 0; i < 4; i++) m_duty[i] = 8'h00;
    endfunction

    function automatic logic [7:0] m_read(logic [6:0] a);
        int k;
        k = int'(a) - 4;
        if (a == 7'h00) return 8'h96;
        if (a == 7'h01) return {6'b0, m_ctrl};
        if (a == 7'h02) return m_pre;
        if (a == 7'h03) return m_per;
        if (k >= 0 && k < 4) return m_duty[k];
        return 8'h00;
    endfunction

    function automatic void m_write(logic [6:0] a, logic [7:0] d);
        int k;
        k = int'(a) - 4;
        if (a == 7'h01) m_ctrl = d[1:0];
        if (a == 7'h02) m_pre = d;
        if (a == 7'h03) m_per = d;
        if (k >= 0 && k < 4) m_duty[k] = d;
    endfunction

    task automatic clks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(logic [15:0] w, int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            clks(HALF);
            sclk = 1'b1;
            clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(logic [7:0] b0, logic [7:0] b1, int nbits);
        if (nbits == 16) begin
            if (b0[7]) m_write(b0[6:0], b1);
            else rd_q.push_back(m_read(b0[6:0]));
        end
        cs_n = 1'b0;
        clks(4);
        spi_bits({b0, b1}, nbits);
        clks(4);
        cs_n = 1'b1;
        clks(6);
    endtask

    task automatic wr(logic [6:0] a, logic [7:0] d);
        frame({1'b1, a}, d, 16);
    endtask

    task automatic rd(logic [6:0] a);
        frame({1'b0, a}, 8'($urandom), 16);
    endtask

    task automatic preq(int kind, int ch, int a, int b, int c, logic [3:0] mask, logic [3:0] v);
        req_t r;
        r.kind = kind; r.ch = ch; r.a = a; r.b = b; r.c = c; r.mask = mask; r.v = v;
        pq.push_back(r);
        p_req++;
    endtask

    task automatic wait_pwm();
        int t;
        t = 0;
        while (p_done != p_req && t < 20000) begin
            clks(1);
            t++;
        end
        if (p_done != p_req) check("pwm_wait", p_done, p_req);
    endtask

    // expected pulse from the register values: duty ticks high out of PERIOD+1, each PRESCALE+1 clks
    task automatic pwm_meas(int ch);
        int d;
        d = (int'(m_duty[ch]) > int'(m_per)) ? int'(m_per) + 1 : int'(m_duty[ch]);
        preq(0, ch, d * (int'(m_pre) + 1), (int'(m_per) + 1) * (int'(m_pre) + 1), 0, 4'h0, 4'h0);
        wait_pwm();
    endtask

    task automatic pwm_const(logic [3:0] mask, logic [3:0] v);
        preq(1, 0, 0, 0, 120, mask, v);
        wait_pwm();
    endtask

    // SPI monitor: decodes each frame from the pins and scores read data
    initial forever begin
        logic [7:0] cmd, got;
        int         nb;
        @(negedge cs_n);
        nb = 0; cmd = 8'h00; got = 8'h00;
        while (cs_n == 1'b0) begin
            @(posedge sclk or posedge cs_n);
            if (!cs_n) begin
                if (nb < 8) cmd = {cmd[6:0], mosi};
                else if (nb < 16) got = {got[6:0], miso};
                nb++;
            end
        end
        if (nb == 16 && !cmd[7]) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else check($sformatf("rd_%02h", cmd[6:0]), int'(got), int'(rd_q.pop_front()));
        end
    end

    // PWM monitor: serves measurement requests on pwm_out
    initial forever begin
        req_t r;
        int   t, hi, lo, len, bad, last, seen, got_new, act;
        logic prev, s;
        @(negedge clk);
        if (pq.size() != 0) begin
            r = pq.pop_front();
            if (r.kind == 0) begin
                t = 0; hi = 0; lo = 0;
                while (pwm_out[r.ch] !== 1'b0 && t < 3000) begin clks(1); t++; end
                while (pwm_out[r.ch] !== 1'b1 && t < 3000) begin clks(1); t++; end
                while (pwm_out[r.ch] === 1'b1 && t < 3000) begin clks(1); hi++; t++; end
                while (pwm_out[r.ch] === 1'b0 && t < 3000) begin clks(1); lo++; t++; end
                check($sformatf("pwm%0d_high", r.ch), hi, r.a);
                check($sformatf("pwm%0d_period", r.ch), hi + lo, r.b);
            end else if (r.kind == 1) begin
                act = int'(r.v);
                for (int k = 0; k < r.c; k++) begin
                    if ((pwm_out & r.mask) !== r.v && act == int'(r.v)) act = int'(pwm_out & r.mask);
                    clks(1);
                end
                check("pwm_const", act, int'(r.v));
            end else begin
                len = 0; bad = 0; last = 0; seen = 0; got_new = 0;
                prev = pwm_out[0];
                for (int k = 0; k < r.c; k++) begin
                    clks(1);
                    s = pwm_out[0];
                    if (!prev && s) begin seen = 1; len = 0; end
                    if (s) len++;
                    if (prev && !s && seen != 0) begin
                        if (!((len == r.a && got_new == 0) || len == r.b)) bad++;
                        if (len == r.b) got_new = 1;
                        last = len;
                    end
                    prev = s;
                end
                check("duty_change_runts", bad, 0);
                check("duty_change_new_len", last, r.b);
            end
            p_done++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exceeded, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        clks(3);
        check("rst_miso", int'(miso), 0);
        check("rst_pwm", int'(pwm_out), 0);
        rst_n = 1'b1;
        clks(5);
        rd(7'h00); rd(7'h03); rd(7'h7F); rd(7'h01); rd(7'h02); rd(7'h04);

        wr(7'h02, 8'h00); wr(7'h03, 8'h09); wr(7'h04, 8'h03); wr(7'h01, 8'h01);
        rd(7'h03); rd(7'h04);
        clks(50);
        pwm_meas(0);
        pwm_const(4'hE, 4'h0);

        preq(2, 0, 3, 7, 600, 4'h0, 4'h0);
        wr(7'h04, 8'h07);
        wait_pwm();
        pwm_meas(0);
        wr(7'h04, 8'h0A);
        clks(30);
        pwm_const(4'h1, 4'h1);

        frame(8'h85, 8'h55, 12);
        rd(7'h05);
        wr(7'h05, 8'h55);
        rd(7'h05);
        wr(7'h05, 8'h00);

        wr(7'h04, 8'h00); wr(7'h01, 8'h03);
        clks(30);
        pwm_const(4'hF, 4'hF);
        wr(7'h01, 8'h02);
        clks(30);
        pwm_const(4'hF, 4'hF);
        rd(7'h01);

        repeat (3) begin
            logic [7:0] pre, per;
            wr(7'h01, 8'h00);
            pre = 8'($urandom_range(0, 3));
            per = 8'($urandom_range(2, 15));
            for (int ch = 0; ch < 4; ch++) wr(7'(4 + ch), 8'($urandom_range(1, int'(per))));
            wr(7'h02, pre); wr(7'h03, per); wr(7'h01, 8'h01);
            clks(200);
            pwm_meas($urandom_range(0, 3));
        end

        for (int i = 0; i < 16; i++) begin
            logic [6:0] a;
            a = 7'($urandom_range(0, 9));
            if (a > 7'h07) a = 7'($urandom);
            if ($urandom_range(0, 1) == 1) wr(a, 8'($urandom));
            else rd(a);
        end

        wr(7'h01, 8'h00); wr(7'h02, 8'h00); wr(7'h03, 8'h09); wr(7'h04, 8'h0A); wr(7'h01, 8'h01);
        clks(30);
        cs_n = 1'b0;
        clks(4);
        spi_bits(16'h0000, 8);
        clks(6);
        check("pre_rst_miso", int'(miso), 1);
        check("pre_rst_pwm0", int'(pwm_out[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_miso", int'(miso), 0);
        check("async_rst_pwm", int'(pwm_out), 0);
        m_reset();
        cs_n = 1'b1;
        clks(5);
        rst_n = 1'b1;
        clks(5);
        rd(7'h00); rd(7'h03); rd(7'h01); rd(7'h02); rd(7'h04);
        clks(20);
        pwm_const(4'hF, 4'h0);
        clks(10);
        check("rd_q_drained", rd_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
